// File: rtl/codec_config_sequencer_pkg.sv
// Shared definitions for the codec configuration sequencer:
// state encoding, table field widths and the default init table.
package codec_config_sequencer_pkg;

    localparam int ADDR_W      = 7;
    localparam int VAL_W       = 9;
    localparam int MAX_ENTRIES = 16;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD       = 4'd1;
    localparam logic [3:0] S_ISSUE      = 4'd2;
    localparam logic [3:0] S_WAIT_START = 4'd3;
    localparam logic [3:0] S_WAIT_DONE  = 4'd4;
    localparam logic [3:0] S_CHECK      = 4'd5;
    localparam logic [3:0] S_NEXT       = 4'd6;
    localparam logic [3:0] S_DONE       = 4'd7;
    localparam logic [3:0] S_FAIL       = 4'd8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [VAL_W-1:0]  val;
    } init_entry_t;

    // Default codec bring-up: reset, power, format, rate, volume, activate.
    function automatic init_entry_t init_entry(input logic [3:0] idx);
        init_entry_t e;
        e = '0;
        case (idx)
            4'd0:    e = '{addr: 7'h0F, val: 9'h000};
            4'd1:    e = '{addr: 7'h06, val: 9'h010};
            4'd2:    e = '{addr: 7'h07, val: 9'h00A};
            4'd3:    e = '{addr: 7'h08, val: 9'h000};
            4'd4:    e = '{addr: 7'h02, val: 9'h079};
            4'd5:    e = '{addr: 7'h03, val: 9'h079};
            4'd6:    e = '{addr: 7'h04, val: 9'h012};
            4'd7:    e = '{addr: 7'h05, val: 9'h000};
            4'd8:    e = '{addr: 7'h06, val: 9'h000};
            4'd9:    e = '{addr: 7'h09, val: 9'h001};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/codec_config_sequencer_rom.sv
// Combinational init table lookup; entries past NUM_REGS read as zero.
module codec_init_rom
    import codec_config_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 10
) (
    input  logic [3:0]  index,
    output init_entry_t entry
);

    localparam logic [4:0] LIMIT = 5'(NUM_REGS);

    always_comb begin
        entry = '0;
        if ({1'b0, index} < LIMIT) begin
            entry = init_entry(index);
        end
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the codec init table, handing each word to an external
// I2C master with per-word NACK retry and a start timeout.
module codec_config_sequencer
    import codec_config_sequencer_pkg::*;
#(
    parameter int          NUM_REGS      = 10,
    parameter logic [7:0]  DEV_ADDR      = 8'h34,
    parameter int          MAX_RETRY     = 3,
    parameter int          START_TIMEOUT = 1023
) (
    input  logic        inClock,
    input  logic        rst,
    input  logic        start,
    output logic [23:0] i2c_data,
    output logic        i2c_go,
    input  logic        i2c_busy,
    input  logic        i2c_ack,
    output logic [3:0]  index,
    output logic        done,
    output logic        error
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TO_LAST   = TW'(START_TIMEOUT - 1);
    localparam logic [3:0]    LAST_IDX  = 4'(NUM_REGS - 1);

    logic [3:0]    state;
    logic [RW-1:0] retry;
    logic [TW-1:0] timeout;
    logic          start_q;
    logic          ack_q;
    logic          start_rise;
    init_entry_t   entry;

    assign start_rise = start & ~start_q;

    codec_init_rom #(
        .NUM_REGS(NUM_REGS)
    ) u_rom (
        .index(index),
        .entry(entry)
    );

    always_ff @(posedge inClock) begin
        if (rst) begin
            state    <= S_IDLE;
            index    <= '0;
            retry    <= '0;
            timeout  <= '0;
            i2c_go   <= 1'b0;
            i2c_data <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            ack_q    <= 1'b0;
            start_q  <= 1'b1;
        end else begin
            start_q <= start;
            i2c_go  <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start_rise) begin
                        index <= '0;
                        retry <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    i2c_data <= {DEV_ADDR, entry};
                    i2c_go   <= 1'b1;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    timeout <= '0;
                    state   <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (i2c_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (timeout >= TO_LAST) begin
                        error <= 1'b1;
                        state <= S_FAIL;
                    end else begin
                        timeout <= timeout + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i2c_busy) begin
                        ack_q <= i2c_ack;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (ack_q) begin
                        state <= S_NEXT;
                    end else if (retry < RETRY_MAX) begin
                        retry  <= retry + 1'b1;
                        i2c_go <= 1'b1;
                        state  <= S_ISSUE;
                    end else begin
                        error <= 1'b1;
                        state <= S_FAIL;
                    end
                end
                S_NEXT: begin
                    if (index == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        index <= index + 4'd1;
                        retry <= '0;
                        state <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Scenario bench for codec_config_sequencer with a behavioural
// I2C master and a scoreboard of expected transfer words.
module tb_codec_config_sequencer;

    localparam int NR       = 3;
    localparam int MR       = 3;
    localparam int ST       = 40;
    localparam int BUSY_LEN = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        ack;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic [3:0]  index;
    logic        done;
    logic        error;

    int n_tests    = 0;
    int n_fail     = 0;
    int go_count   = 0;
    int nack_idx   = -1;
    int nacks_left = 0;
    bit never_busy = 1'b0;
    bit m_active   = 1'b0;

    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;
    logic [23:0] word_tbl [3] = '{24'h341E00, 24'h340C10, 24'h340E0A};

    always #5 clk = ~clk;

    codec_config_sequencer #(
        .NUM_REGS(NR),
        .DEV_ADDR(8'h34),
        .MAX_RETRY(MR),
        .START_TIMEOUT(ST)
    ) dut (
        .inClock(clk),
        .rst(rst),
        .start(start),
        .i2c_data(i2c_data),
        .i2c_go(i2c_go),
        .i2c_busy(busy),
        .i2c_ack(ack),
        .index(index),
        .done(done),
        .error(error)
    );

    // Behavioural master: busy from the cycle after go, ack on busy fall.
    initial begin
        busy = 1'b0;
        ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_go === 1'b1 && !never_busy) begin
                m_active = 1'b1;
                @(posedge clk);
                #1 busy = 1'b1;
                ack = 1'b0;
                repeat (BUSY_LEN) @(posedge clk);
                #1;
                if (int'(index) == nack_idx && nacks_left > 0) begin
                    ack = 1'b0;
                    nacks_left--;
                end else begin
                    ack = 1'b1;
                end
                busy = 1'b0;
                @(posedge clk);
                #1 ack = 1'b0;
                m_active = 1'b0;
            end
        end
    end

    // Scoreboard: every go pulse pops one expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (i2c_go === 1'b1) begin
                go_count++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL go_word: unexpected go data=%h required no go", i2c_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (i2c_data !== mon_exp) begin
                        n_fail++;
                        $display("FAIL go_word: got %h required %h", i2c_data, mon_exp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_edge();
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
    endtask

    task automatic wait_end(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done || error) begin
                to = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_go_idx(input logic [3:0] idx, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i2c_go === 1'b1 && index == idx) begin
                to = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_master_idle();
        for (int i = 0; i < 200; i++) begin
            if (!m_active) return;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (i2c_go !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: go=%b done=%b error=%b required 0", i2c_go, done, error);
        end
        n_tests++;
        if (index !== 4'd0 || i2c_data !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data: index=%0d data=%h required 0/0", index, i2c_data);
        end
        rst = 1'b0;
        repeat (20) tick();
        n_tests++;
        if (go_count !== 0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held_start: go=%0d done=%b required 0/0", go_count, done);
        end
    endtask

    task automatic test_basic();
        bit to;
        go_count = 0;
        for (int i = 0; i < NR; i++) exp_q.push_back(word_tbl[i]);
        start_edge();
        wait_end(1000, to);
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL basic_wait: got timeout required done/error");
        end
        n_tests++;
        if (go_count !== 3 || done !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: go=%0d done=%b error=%b required 3/1/0", go_count, done, error);
        end
        n_tests++;
        if (index !== 4'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_index: index=%0d left=%0d required 2/0", index, exp_q.size());
        end
        wait_master_idle();
    endtask

    task automatic test_nack_retry();
        bit to;
        go_count = 0;
        nack_idx = 1;
        nacks_left = 1;
        exp_q.push_back(word_tbl[0]);
        exp_q.push_back(word_tbl[1]);
        exp_q.push_back(word_tbl[1]);
        exp_q.push_back(word_tbl[2]);
        start_edge();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_done_clear: got %b required 0", done);
        end
        wait_end(1000, to);
        n_tests++;
        if (to || go_count !== 4 || done !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_end: to=%b go=%0d done=%b error=%b required 0/4/1/0",
                     to, go_count, done, error);
        end
        n_tests++;
        if (exp_q.size() != 0 || nacks_left != 0) begin
            n_fail++;
            $display("FAIL retry_queue: left=%0d nacks=%0d required 0/0", exp_q.size(), nacks_left);
        end
        nack_idx = -1;
        wait_master_idle();
    endtask

    task automatic test_retry_exhaust();
        bit to;
        go_count = 0;
        nack_idx = 0;
        nacks_left = 99;
        repeat (MR + 1) exp_q.push_back(word_tbl[0]);
        start_edge();
        wait_end(1000, to);
        n_tests++;
        if (to || go_count !== 4 || error !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL exhaust_end: to=%b go=%0d error=%b done=%b required 0/4/1/0",
                     to, go_count, error, done);
        end
        n_tests++;
        if (index !== 4'd0) begin
            n_fail++;
            $display("FAIL exhaust_index: got %0d required 0", index);
        end
        repeat (50) tick();
        n_tests++;
        if (go_count !== 4 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL exhaust_quiet: go=%0d error=%b required 4/1", go_count, error);
        end
        nack_idx = -1;
        nacks_left = 0;
        wait_master_idle();
    endtask

    task automatic test_timeout();
        bit to;
        int cnt;
        never_busy = 1'b1;
        go_count = 0;
        exp_q.push_back(word_tbl[0]);
        start_edge();
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_clear: got %b required 0", error);
        end
        wait_go_idx(4'd0, 10, to);
        cnt = 0;
        for (int i = 0; i < ST + 20; i++) begin
            tick();
            cnt++;
            if (error) break;
        end
        n_tests++;
        if (to || cnt != ST + 1 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_cycles: to=%b cycles=%0d error=%b required 0/%0d/1",
                     to, cnt, error, ST + 1);
        end
        repeat (30) tick();
        n_tests++;
        if (go_count !== 1 || done !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_quiet: go=%0d done=%b left=%0d required 1/0/0",
                     go_count, done, exp_q.size());
        end
        never_busy = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit to;
        go_count = 0;
        for (int i = 0; i < NR; i++) exp_q.push_back(word_tbl[i]);
        start_edge();
        wait_go_idx(4'd2, 500, to);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (to || i2c_go !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_flags: to=%b go=%b done=%b error=%b required 0",
                     to, i2c_go, done, error);
        end
        n_tests++;
        if (index !== 4'd0 || i2c_data !== 24'h0) begin
            n_fail++;
            $display("FAIL midreset_data: index=%0d data=%h required 0/0", index, i2c_data);
        end
        rst = 1'b0;
        wait_master_idle();
        repeat (30) tick();
        n_tests++;
        if (go_count !== 3 || exp_q.size() != 0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_quiet: go=%0d left=%0d done=%b required 3/0/0",
                     go_count, exp_q.size(), done);
        end
        go_count = 0;
        for (int i = 0; i < NR; i++) exp_q.push_back(word_tbl[i]);
        start_edge();
        wait_end(1000, to);
        n_tests++;
        if (to || go_count !== 3 || done !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_restart: to=%b go=%0d done=%b left=%0d required 0/3/1/0",
                     to, go_count, done, exp_q.size());
        end
        wait_master_idle();
    endtask

    task automatic test_start_hold();
        bit to;
        go_count = 0;
        repeat (50) tick();
        n_tests++;
        if (go_count !== 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_no_retrigger: go=%0d done=%b required 0/1", go_count, done);
        end
        for (int i = 0; i < NR; i++) exp_q.push_back(word_tbl[i]);
        start_edge();
        wait_go_idx(4'd0, 20, to);
        repeat (5) tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        wait_end(1000, to);
        n_tests++;
        if (to || go_count !== 3 || done !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_one_pass: to=%b go=%0d done=%b error=%b required 0/3/1/0",
                     to, go_count, done, error);
        end
        repeat (50) tick();
        n_tests++;
        if (go_count !== 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL hold_ignored_edge: go=%0d left=%0d required 3/0", go_count, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic();
        test_nack_retry();
        test_retry_exhaust();
        test_timeout();
        test_reset_mid();
        test_start_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
